// File: rtl/mult_pipe_mac_if.sv
// Operand/result handshake bundle for mult_pipe_mac.
// Master drives operands and result-ready; slave is the MAC datapath.
interface mult_pipe_mac_if #(
  parameter int AW    = 18,
  parameter int BW    = 18,
  parameter int GUARD = 8
);
  localparam int OW = AW + BW + GUARD;

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_a;
  logic [BW-1:0] in_b;
  logic          in_signed;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/mult_pipe_mac.sv
// Pipelined signed/unsigned multiplier with accumulate, valid/ready on both sides.
// Stage 1 registers operands, stages 2..LAT-1 carry the product, stage LAT accumulates/outputs.
module mult_pipe_mac #(
  parameter int AW    = 18,
  parameter int BW    = 18,
  parameter int LAT   = 3,
  parameter int GUARD = 8
) (
  input  logic clk,
  input  logic rst,
  mult_pipe_mac_if.slave bus
);
  localparam int PW = AW + BW;
  localparam int OW = PW + GUARD;
  localparam int PD = (LAT > 2) ? (LAT - 2) : 1;

  // Two's-complement product is the low PW bits of the PW-wide extended operands.
  function automatic logic [PW-1:0] full_product(input logic [AW-1:0] a,
                                                 input logic [BW-1:0] b,
                                                 input logic          sg);
    logic [PW-1:0] ax;
    logic [PW-1:0] bx;
    ax = sg ? {{BW{a[AW-1]}}, a} : {{BW{1'b0}}, a};
    bx = sg ? {{AW{b[BW-1]}}, b} : {{AW{1'b0}}, b};
    return ax * bx;
  endfunction

  logic          stall_s;
  logic          s1_valid_r;
  logic [AW-1:0] s1_a_r;
  logic [BW-1:0] s1_b_r;
  logic          s1_signed_r;
  logic [1:0]    s1_mode_r;
  logic [PW-1:0] prod_s;

  logic          tail_valid_s;
  logic [PW-1:0] tail_prod_s;
  logic          tail_signed_s;
  logic [1:0]    tail_mode_s;

  logic          out_valid_r;
  logic [OW-1:0] out_data_r;
  logic          out_ovf_r;
  logic [OW-1:0] acc_r;

  logic [OW-1:0] ext_s;
  logic [OW:0]   sum_wide_s;
  logic [OW-1:0] nxt_data_s;
  logic          nxt_ovf_s;
  logic [OW-1:0] nxt_acc_s;

  // A held result freezes the whole pipe; reset always presents ready.
  assign stall_s      = out_valid_r && !bus.out_ready;
  assign bus.in_ready = rst || !stall_s;
  assign prod_s       = full_product(s1_a_r, s1_b_r, s1_signed_r);

  // Operand stage: captures the beat, or a bubble when nothing is offered.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_a_r      <= '0;
      s1_b_r      <= '0;
      s1_signed_r <= 1'b0;
      s1_mode_r   <= 2'b00;
    end else if (!stall_s) begin
      s1_valid_r  <= bus.in_valid;
      s1_a_r      <= bus.in_a;
      s1_b_r      <= bus.in_b;
      s1_signed_r <= bus.in_signed;
      s1_mode_r   <= bus.in_mode;
    end
  end

  if (LAT > 2) begin : g_pp
    logic          pv_r [PD];
    logic [PW-1:0] pp_r [PD];
    logic          ps_r [PD];
    logic [1:0]    pm_r [PD];

    // Product shift chain, moving only when the output is not held.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < PD; i++) begin
          pv_r[i] <= 1'b0;
          pp_r[i] <= '0;
          ps_r[i] <= 1'b0;
          pm_r[i] <= 2'b00;
        end
      end else if (!stall_s) begin
        pv_r[0] <= s1_valid_r;
        pp_r[0] <= prod_s;
        ps_r[0] <= s1_signed_r;
        pm_r[0] <= s1_mode_r;
        for (int i = 1; i < PD; i++) begin
          pv_r[i] <= pv_r[i-1];
          pp_r[i] <= pp_r[i-1];
          ps_r[i] <= ps_r[i-1];
          pm_r[i] <= pm_r[i-1];
        end
      end
    end

    assign tail_valid_s  = pv_r[PD-1];
    assign tail_prod_s   = pp_r[PD-1];
    assign tail_signed_s = ps_r[PD-1];
    assign tail_mode_s   = pm_r[PD-1];
  end else begin : g_nopp
    assign tail_valid_s  = s1_valid_r;
    assign tail_prod_s   = prod_s;
    assign tail_signed_s = s1_signed_r;
    assign tail_mode_s   = s1_mode_r;
  end

  // Result/accumulator selection for the beat about to enter the output stage.
  always_comb begin
    ext_s      = tail_signed_s ? {{GUARD{tail_prod_s[PW-1]}}, tail_prod_s}
                               : {{GUARD{1'b0}}, tail_prod_s};
    sum_wide_s = {1'b0, acc_r} + {1'b0, ext_s};
    nxt_data_s = ext_s;
    nxt_ovf_s  = 1'b0;
    nxt_acc_s  = acc_r;
    case (tail_mode_s)
      2'b01: begin
        nxt_data_s = sum_wide_s[OW-1:0];
        nxt_acc_s  = sum_wide_s[OW-1:0];
        if (tail_signed_s) begin
          nxt_ovf_s = (acc_r[OW-1] == ext_s[OW-1]) && (sum_wide_s[OW-1] != acc_r[OW-1]);
        end else begin
          nxt_ovf_s = sum_wide_s[OW];
        end
      end
      2'b10: begin
        nxt_data_s = ext_s;
        nxt_acc_s  = ext_s;
      end
      default: begin
        nxt_data_s = ext_s;
        nxt_acc_s  = acc_r;
      end
    endcase
  end

  // Output/accumulate stage; bubbles advance the valid bit but leave data and acc alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_ovf_r   <= 1'b0;
      acc_r       <= '0;
    end else if (!stall_s) begin
      out_valid_r <= tail_valid_s;
      if (tail_valid_s) begin
        out_data_r <= nxt_data_s;
        out_ovf_r  <= nxt_ovf_s;
        acc_r      <= nxt_acc_s;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_ovf   = out_ovf_r;
endmodule

// File: tb/tb_mult_pipe_mac.sv
// Directed bench for mult_pipe_mac: arithmetic scoreboard checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_mult_pipe_mac;
  localparam int AW = 18;
  localparam int BW = 18;
  localparam int LAT = 3;
  localparam int GUARD = 8;
  localparam int OW = AW + BW + GUARD;
  localparam longint MASK = (64'sd1 <<< OW) - 64'sd1;
  localparam longint SMAX = (64'sd1 <<< (OW - 1)) - 64'sd1;
  localparam longint SMIN = -(64'sd1 <<< (OW - 1));

  typedef struct { longint data; bit ovf; int acc_cyc; int stall_snap; } exp_t;
  typedef struct { longint data; bit ovf; int cyc; int acc_cyc; } got_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   stall_cnt = 0;
  bit   prev_stall = 1'b0;
  logic [OW-1:0] prev_data;
  logic prev_ovf;
  longint model_acc = 0;
  exp_t exp_q[$];
  got_t got[$];

  mult_pipe_mac_if #(.AW(AW), .BW(BW), .GUARD(GUARD)) bus ();

  mult_pipe_mac #(.AW(AW), .BW(BW), .LAT(LAT), .GUARD(GUARD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected result from plain integer arithmetic on the accepted beat.
  function automatic exp_t model(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                 input logic sg, input logic [1:0] mode);
    exp_t e;
    longint pa, pb, p, sacc, s;
    pa = longint'(a);
    pb = longint'(b);
    if (sg && a[AW-1]) pa = pa - (64'sd1 <<< AW);
    if (sg && b[BW-1]) pb = pb - (64'sd1 <<< BW);
    p = pa * pb;
    e.ovf = 1'b0;
    if (mode == 2'b01) begin
      if (sg) begin
        sacc = model_acc;
        if (model_acc > SMAX) sacc = model_acc - (64'sd1 <<< OW);
        s = sacc + p;
        e.ovf = (s > SMAX) || (s < SMIN);
      end else begin
        s = model_acc + p;
        e.ovf = (s > MASK);
      end
      e.data = s & MASK;
      model_acc = e.data;
    end else begin
      e.data = p & MASK;
      if (mode == 2'b10) model_acc = e.data;
    end
    e.acc_cyc = cyc;
    e.stall_snap = stall_cnt;
    return e;
  endfunction

  // Scoreboard: record accepted beats, check every transfer, handshake and stall hold.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_acc = 0;
      prev_stall = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_signed, bus.in_mode));
      chk("in_ready", {63'd0, bus.in_ready}, {63'd0, !(bus.out_valid && !bus.out_ready)});
      if (prev_stall) begin
        chk("hold_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("hold_data", {20'd0, bus.out_data}, {20'd0, prev_data});
        chk("hold_ovf", {63'd0, bus.out_ovf}, {63'd0, prev_ovf});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", {20'd0, bus.out_data}, 64'hDEAD);
        end else begin
          exp_t e;
          got_t g;
          e = exp_q.pop_front();
          chk("out_data", {20'd0, bus.out_data}, e.data);
          chk("out_ovf", {63'd0, bus.out_ovf}, {63'd0, e.ovf});
          chk("latency", 64'(cyc), 64'(e.acc_cyc + LAT + (stall_cnt - e.stall_snap)));
          g.data = longint'(bus.out_data);
          g.ovf = bus.out_ovf;
          g.cyc = cyc;
          g.acc_cyc = e.acc_cyc;
          got.push_back(g);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      if (prev_stall) stall_cnt++;
      prev_data = bus.out_data;
      prev_ovf = bus.out_ovf;
    end
  end

  task automatic send(input logic [AW-1:0] a, input logic [BW-1:0] b,
                      input logic sg, input logic [1:0] mode);
    bit ok;
    int n;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_signed = sg;
    bus.in_mode = mode;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept", {63'd0, ok}, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int ovf_n;
    int s0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_signed = 1'b0;
    bus.in_mode = 2'b00;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_data", {20'd0, bus.out_data}, 64'd0);
    chk("rst_out_ovf", {63'd0, bus.out_ovf}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // 3*5 unsigned, single beat
    got.delete();
    send(18'd3, 18'd5, 1'b0, 2'b00);
    drain();
    chk("s1_count", 64'(got.size()), 64'd1);
    chk("s1_data", got[0].data, 64'd15);
    chk("s1_lat", 64'(got[0].cyc - got[0].acc_cyc), 64'd3);

    // sign handling and the largest unsigned product
    got.delete();
    send(18'h3FFFF, 18'd2, 1'b1, 2'b00);
    send(18'h3FFFF, 18'd2, 1'b0, 2'b00);
    send(18'h3FFFF, 18'h3FFFF, 1'b0, 2'b11);
    drain();
    chk("s2_signed", got[0].data, 64'hFFFFFFFFFFE);
    chk("s2_unsigned", got[1].data, 64'h7FFFE);
    chk("s3_max", got[2].data, 64'hFFFF80001);

    // load then accumulate, back to back
    got.delete();
    send(18'd10, 18'd10, 1'b0, 2'b10);
    send(18'd2, 18'd3, 1'b0, 2'b01);
    send(18'd2, 18'd3, 1'b0, 2'b01);
    drain();
    chk("s4_load", got[0].data, 64'd100);
    chk("s4_acc1", got[1].data, 64'd106);
    chk("s4_acc2", got[2].data, 64'd112);
    chk("s4_spacing", 64'(got[2].cyc - got[0].cyc), 64'd2);

    // signed accumulation marching toward 2^43-1
    got.delete();
    send(18'h1FFFF, 18'h1FFFF, 1'b1, 2'b10);
    for (int i = 0; i < 512; i++) send(18'h1FFFF, 18'h1FFFF, 1'b1, 2'b01);
    drain();
    ovf_n = 0;
    foreach (got[i]) ovf_n += int'(got[i].ovf);
    chk("s5_first_acc", got[1].data, 64'h7FFF80002);
    chk("s5_ovf_count", 64'(ovf_n), 64'd1);
    chk("s5_ovf_last", {63'd0, got[512].ovf}, 64'd1);
    chk("s5_pre_last", {63'd0, got[511].ovf}, 64'd0);

    // stream with out_ready low for four cycles
    got.delete();
    s0 = stall_cnt;
    fork
      for (int i = 1; i <= 8; i++) send(18'(i), 18'd1, 1'b0, 2'b00);
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("s6_stalls", 64'(stall_cnt - s0), 64'd4);
    chk("s6_count", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk("s6_order", got[i].data, 64'(i + 1));

    // reset with beats in flight and a beat offered during reset
    got.delete();
    send(18'd50, 18'd1, 1'b0, 2'b10);
    drain();
    send(18'd3, 18'd3, 1'b0, 2'b00);
    send(18'd4, 18'd4, 1'b0, 2'b00);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a = 18'd7;
    bus.in_b = 18'd7;
    bus.in_mode = 2'b10;
    @(negedge clk);
    chk("s7_ready_in_rst", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("s7_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("s7_out_data", {20'd0, bus.out_data}, 64'd0);
    send(18'd1, 18'd1, 1'b0, 2'b01);
    drain();
    chk("s7_count", 64'(got.size()), 64'd2);
    chk("s7_acc_cleared", got[1].data, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
